// File: rtl/rc5_key_expand_if.sv
// rtl/rc5_key_expand_if.sv - start/key/table-read bundle between controller, decipher and key schedule
interface rc5_key_expand_if #(
   parameter int W        = 32,
   parameter int KW       = 4,
   parameter int T_LENGTH = 5
);
   logic                iStart;
   logic [32*KW-1:0]    iKey;
   logic [T_LENGTH-1:0] iS_address1;
   logic [T_LENGTH-1:0] iS_address2;
   logic [W-1:0]        oS_sub_i1;
   logic [W-1:0]        oS_sub_i2;
   logic                oReady;

   modport master (
      output iStart, iKey, iS_address1, iS_address2,
      input  oS_sub_i1, oS_sub_i2, oReady
   );

   modport slave (
      input  iStart, iKey, iS_address1, iS_address2,
      output oS_sub_i1, oS_sub_i2, oReady
   );
endinterface

// File: rtl/rc5_key_expand.sv
// rtl/rc5_key_expand.sv - RC5-32 key schedule: builds S[0..T-1] and serves it on two async read ports
module rc5_key_expand #(
   parameter  int W        = 32,
   parameter  int R        = 12,
   parameter  int KW       = 4,
   localparam int T        = 2*(R+1),
   localparam int T_LENGTH = $clog2(T)
) (
   input logic           clk,
   input logic           rst,
   rc5_key_expand_if.slave bus
);
   localparam int N  = 3*((T > KW) ? T : KW);
   localparam int CW = $clog2(N+1);
   localparam int JW = (KW > 1) ? $clog2(KW) : 1;
   localparam logic [W-1:0] P = 32'hB7E15163;
   localparam logic [W-1:0] Q = 32'h9E3779B9;

   typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX_A, MIX_B, DONE} state_t;

   state_t state_q, state_d;

   logic [W-1:0]        s_mem [T];
   logic [W-1:0]        l_mem [KW];
   logic [W-1:0]        a_reg, b_reg;
   logic [T_LENGTH-1:0] i_idx, k_idx, k_prev;
   logic [JW-1:0]       j_idx;
   logic [CW-1:0]       mix_cnt;
   logic                ready_q;

   logic latch_key, do_load, do_init, do_mix_a, do_mix_b, ready_d;
   logic last_init, last_mix;
   logic [W-1:0] ab_sum, a_new, b_new;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [4:0] n);
      logic [2*W-1:0] t;
      t = {x, x} << n;
      return t[2*W-1:W];
   endfunction

   assign last_init = (k_idx == T_LENGTH'(T-1));
   assign last_mix  = (mix_cnt == CW'(N-1));
   assign k_prev    = k_idx - T_LENGTH'(1);

   // MIX_B runs one cycle after MIX_A, so a_reg already holds the fresh A here.
   assign a_new  = rotl(s_mem[i_idx] + a_reg + b_reg, 5'd3);
   assign ab_sum = a_reg + b_reg;
   assign b_new  = rotl(l_mem[j_idx] + ab_sum, ab_sum[4:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (bus.iStart) state_d = LOAD;
         LOAD:       state_d = INIT;
         INIT:       if (last_init) state_d = MIX_A;
         MIX_A:      state_d = MIX_B;
         MIX_B:      state_d = last_mix ? DONE : MIX_A;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      latch_key = 1'b0;
      do_load   = 1'b0;
      do_init   = 1'b0;
      do_mix_a  = 1'b0;
      do_mix_b  = 1'b0;
      ready_d   = 1'b0;
      case (state_q)
         IDLE:    latch_key = bus.iStart;
         LOAD:    do_load   = 1'b1;
         INIT:    do_init   = 1'b1;
         MIX_A:   do_mix_a  = 1'b1;
         MIX_B:   do_mix_b  = 1'b1;
         DONE: begin
            latch_key = bus.iStart;
            ready_d   = !bus.iStart;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < T; t++)  s_mem[t] <= '0;
         for (int t = 0; t < KW; t++) l_mem[t] <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         i_idx   <= '0;
         j_idx   <= '0;
         k_idx   <= '0;
         mix_cnt <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
         if (latch_key) begin
            for (int t = 0; t < KW; t++) l_mem[t] <= bus.iKey[32*t +: 32];
            a_reg   <= '0;
            b_reg   <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            k_idx   <= '0;
            mix_cnt <= '0;
         end
         if (do_load) begin
            s_mem[0] <= P;
            k_idx    <= T_LENGTH'(1);
         end
         if (do_init) begin
            s_mem[k_idx] <= s_mem[k_prev] + Q;
            if (last_init) begin
               k_idx   <= '0;
               mix_cnt <= '0;
            end else begin
               k_idx <= k_idx + T_LENGTH'(1);
            end
         end
         if (do_mix_a) begin
            a_reg        <= a_new;
            s_mem[i_idx] <= a_new;
         end
         if (do_mix_b) begin
            b_reg        <= b_new;
            l_mem[j_idx] <= b_new;
            i_idx        <= (i_idx == T_LENGTH'(T-1)) ? '0 : i_idx + T_LENGTH'(1);
            j_idx        <= (j_idx == JW'(KW-1)) ? '0 : j_idx + JW'(1);
            mix_cnt      <= mix_cnt + CW'(1);
         end
      end
   end

   // Addresses past the table end read as zero rather than aliasing.
   always_comb begin
      bus.oS_sub_i1 = '0;
      bus.oS_sub_i2 = '0;
      if ({1'b0, bus.iS_address1} < (T_LENGTH+1)'(T)) bus.oS_sub_i1 = s_mem[bus.iS_address1];
      if ({1'b0, bus.iS_address2} < (T_LENGTH+1)'(T)) bus.oS_sub_i2 = s_mem[bus.iS_address2];
   end

   assign bus.oReady = ready_q;
endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

RC5-32 key-schedule stage that sits directly upstream of the decipher engine. It expands a secret key of KW 32-bit words into the round-key table S[0..T-1], where T = 2*(R+1). It holds the table in an internal register array and serves it through two asynchronous read ports. These ports connect straight to the decipher's S-address outputs and S-data inputs. oReady tells the controller that the table is valid and that deciphering may start.

## Interface
- W, 32: word width; only 32 is supported because the P/Q constants are RC5-32.
- R, 12: number of rounds; must match the decipher's R.
- KW, 4: key length in 32-bit words (4 gives a 128-bit key).
- T, 2*(R+1): table depth (derived, do not override).
- T_LENGTH, $clog2(T): address width (derived).
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- iStart  in  1  start pulse; sampled only in IDLE and DONE.
- iKey  in  32*KW  key, sampled on the iStart edge; key byte k is iKey[8k+7:8k], so L[j] = iKey[32j+31:32j].
- iS_address1  in  T_LENGTH  read address, port 1.
- iS_address2  in  T_LENGTH  read address, port 2.
- oS_sub_i1  out  W  S[iS_address1], combinational; 0 if address ≥ T.
- oS_sub_i2  out  W  S[iS_address2], combinational; 0 if address ≥ T.
- oReady  out  1  table valid; high from schedule completion until the next accepted iStart or reset.

## Operation
- Constants: P = 0xB7E15163, Q = 0x9E3779B9. All arithmetic is mod 2^32. Rotate amount is the low 5 bits of its operand, and rotates are left rotates.
- Internal registers:
  - S[0..T-1], L[0..KW-1], A, B;
  - index i (mod T) and index j (mod KW);
  - mix counter, sized to reach N = 3*max(T,KW).
- State machine:
  - IDLE: wait for iStart. On iStart, latch L from iKey, zero A/B/i/j/k, then go to LOAD.
  - LOAD: write S[0] = P and set k = 1. Then go to INIT.
  - INIT: one word per cycle, S[k] = S[k-1] + Q, for k = 1..T-1. After S[T-1] is written, zero k and the mix counter, then go to MIX_A.
  - MIX_A: A ← (S[i] + A + B) <<< 3, and S[i] ← the same value. Then go to MIX_B.
  - MIX_B: B ← (L[j] + A + B) <<< (A + B), and L[j] ← the same value, using the A just updated. Advance i and j, each wrapping mod its range, and increment the counter. If the counter reaches N, go to DONE; otherwise return to MIX_A.
  - DONE: oReady = 1. On iStart, latch the new key, drop oReady on that same edge and enter LOAD (restart).
- iStart is ignored in LOAD, INIT, MIX_A and MIX_B.
- Read ports reflect the live array contents in every state. Data are meaningful only while oReady = 1.
- Reset, at any time including mid-schedule:
  - state goes to IDLE;
  - all S[], L[], A, B, i, j, k and the counter clear to 0;
  - oReady = 0, and oS_sub_i1 = oS_sub_i2 = 0.

## Timing
- Schedule latency: oReady rises 1 + (T-1) + 2N + 1 edges after the edge that accepts iStart. Counted as:
  - 1 edge from IDLE/DONE to LOAD;
  - 1 edge for LOAD;
  - T-1 edges for INIT;
  - 2N edges for mixing;
  - the final MIX_B edge enters DONE, so oReady is high the cycle after it.
- With defaults (T = 26, KW = 4, N = 78), oReady is first high 183 cycles after the accepting edge.
- Read ports have zero latency, which is compatible with the decipher's address-then-wait read sequence.
- oReady is a registered output with no glitches.
- Key independence: once iStart is accepted, iKey may change freely.

## Test plan
- Reset behaviour: assert rst asynchronously between edges → oReady = 0 and both read ports = 0 immediately. Release rst and read addresses 0..25 → all return 0.
- Zero key, schedule: iKey = 0, pulse iStart → oReady is first high 183 cycles later. Table checked against the golden C model for RC5-32/12/16 with key 0.
- End-to-end zero key: connect the decipher, wait for oReady, decipher A = 0xEEDBA521, B = 0x6D8F4B15 → outputs A = 0x00000000, B = 0x00000000.
- Start while busy: pulse iStart again at cycle 50 with a different key → ignored. oReady still rises at cycle 183 and the table matches the first key.
- Restart from DONE: load key 0, wait for oReady, then start with a non-zero key → oReady drops the next cycle and rises again 183 cycles later. The table matches the golden model for the new key.
- Mid-schedule reset and address bounds:
  - rst during MIX, then a new start → correct full schedule, latency 183;
  - read address 26..31 → returns 0.
